// File: rtl/lp805x_sfr_arb.sv
// lp805x_sfr_arb: round-robin arbiter that sequences one shared SFR access channel.
// state  | meaning: IDLE pick winner | ACCESS p_sel held, await p_rdy | DONE one-cycle completion
module lp805x_sfr_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int TMO  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdat,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdat,
  output logic               err,
  output logic               p_sel,
  output logic               p_wr,
  output logic [AW-1:0]      p_addr,
  output logic [DW-1:0]      p_wdat,
  input  logic               p_rdy,
  input  logic [DW-1:0]      p_rdat
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] widx;
  logic [PW-1:0] win;
  logic [PW:0]   idx;
  logic [7:0]    cnt;
  logic          found;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdat;

  // Scan ptr, ptr+1, ... with wrap; first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_wdat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        sel_wr   = wr[i];
        sel_addr = addr[i*AW +: AW];
        sel_wdat = wdat[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      widx   <= '0;
      cnt    <= '0;
      gnt    <= '0;
      done   <= '0;
      rdat   <= '0;
      err    <= 1'b0;
      p_sel  <= 1'b0;
      p_wr   <= 1'b0;
      p_addr <= '0;
      p_wdat <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (found) begin
            gnt    <= NREQ'(1) << win;
            widx   <= win;
            p_wr   <= sel_wr;
            p_addr <= sel_addr;
            p_wdat <= sel_wdat;
            p_sel  <= 1'b1;
            err    <= 1'b0;
            cnt    <= '0;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // p_rdy takes priority over a coincident timeout.
          if (p_rdy) begin
            if (!p_wr) rdat <= p_rdat;
            p_sel <= 1'b0;
            done  <= gnt;
            state <= DONE;
          end else if (cnt == 8'(TMO-1)) begin
            if (!p_wr) rdat <= '1;
            p_sel <= 1'b0;
            err   <= 1'b1;
            done  <= gnt;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          ptr   <= (widx == PW'(NREQ-1)) ? '0 : widx + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lp805x_sfr_arb.sv
// Directed bench for lp805x_sfr_arb: transaction-level model checked every cycle plus literal pins.
module tb_lp805x_sfr_arb;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int TMO  = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    wr  = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdat = '0;
  logic [NREQ-1:0]    gnt, done;
  logic [DW-1:0]      rdat;
  logic               err, p_sel, p_wr;
  logic [AW-1:0]      p_addr;
  logic [DW-1:0]      p_wdat;
  logic               p_rdy = 1'b0;
  logic [DW-1:0]      p_rdat = '0;

  lp805x_sfr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdat(wdat),
    .gnt(gnt), .done(done), .rdat(rdat), .err(err), .p_sel(p_sel), .p_wr(p_wr),
    .p_addr(p_addr), .p_wdat(p_wdat), .p_rdy(p_rdy), .p_rdat(p_rdat)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the channel, how long it has waited, whose turn is next.
  int            m_owner;
  int            m_wait;
  bit            m_closing;
  int            m_next;
  logic [NREQ-1:0] e_gnt, e_done;
  logic [DW-1:0] e_rdat;
  logic          e_err, e_sel, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdat;

  task automatic model_reset();
    m_owner = -1; m_wait = 0; m_closing = 0; m_next = 0;
    e_gnt = '0; e_done = '0; e_rdat = '0; e_err = 0; e_sel = 0; e_wr = 0;
    e_addr = '0; e_wdat = '0;
  endtask

  task automatic model_step();
    if (m_closing) begin
      m_next = (m_owner + 1) % NREQ;
      m_owner = -1; m_closing = 0;
      e_gnt = '0; e_done = '0;
    end else if (m_owner >= 0) begin
      if (p_rdy) begin
        if (!e_wr) e_rdat = p_rdat;
        e_sel = 0; e_done = e_gnt; m_closing = 1;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          if (!e_wr) e_rdat = '1;
          e_sel = 0; e_err = 1; e_done = e_gnt; m_closing = 1;
        end
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_next + k) % NREQ;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_wait = 0;
          e_gnt = '0; e_gnt[c] = 1'b1;
          e_wr = wr[c]; e_addr = addr[c*AW +: AW]; e_wdat = wdat[c*DW +: DW];
          e_sel = 1; e_err = 0;
        end
      end
    end
  endtask

  // Monitors fed from the compare process.
  int   glog[$];
  logic [NREQ-1:0] prev_gnt = '0;
  int   sel_run = 0;
  int   sel_len = 0;

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("done", 32'(done), 32'(e_done));
      chk("rdat", 32'(rdat), 32'(e_rdat));
      chk("err", 32'(err), 32'(e_err));
      chk("p_sel", 32'(p_sel), 32'(e_sel));
      if (e_sel) begin
        chk("p_wr", 32'(p_wr), 32'(e_wr));
        chk("p_addr", 32'(p_addr), 32'(e_addr));
        chk("p_wdat", 32'(p_wdat), 32'(e_wdat));
      end
      if (prev_gnt == '0 && gnt != '0)
        for (int k = 0; k < NREQ; k++) if (gnt[k]) glog.push_back(k);
      prev_gnt = gnt;
      if (p_sel) sel_run++;
      else if (sel_run > 0) begin sel_len = sel_run; sel_run = 0; end
    end
  end

  // Peripheral: answer on the lat-th cycle of p_sel; lat==0 never answers.
  int lat = 1;
  int sel_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (p_sel) sel_cyc++; else sel_cyc = 0;
      p_rdy = p_sel && (lat != 0) && (sel_cyc == lat);
    end
  end

  task automatic wait_done(input int budget, output int ncyc);
    ncyc = 0;
    while (done == '0 && ncyc < budget) begin
      @(negedge clk);
      ncyc++;
    end
    if (done == '0) chk("done_timeout", 32'(done), 32'hFFFF_FFFF);
  endtask

  task automatic finish_txn();
    req = '0;
    @(negedge clk);
    chk("done_width", 32'(done), 32'h0);
  endtask

  int n;
  int exp_order[8];

  initial begin
    exp_order = '{0, 1, 2, 3, 0, 1, 3, 1};
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_psel", 32'(p_sel), 32'h0);
    chk("rst_rdat", 32'(rdat), 32'h0);
    rst = 0;
    @(negedge clk);

    // Single read, peripheral answers on second p_sel cycle
    lat = 2; p_rdat = 8'h5A;
    wr = '0; addr[2*AW +: AW] = 8'h81; req = 4'b0100;
    @(negedge clk); n = 1;
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_addr", 32'(p_addr), 32'h81);
    begin int m; wait_done(40, m); n += m; end
    chk("rd_latency", 32'(n), 32'd3);
    chk("rd_done", 32'(done), 32'h4);
    chk("rd_rdat", 32'(rdat), 32'h5A);
    chk("rd_err", 32'(err), 32'h0);
    chk("rd_sel_len", 32'(sel_len), 32'd2);
    finish_txn();

    // Write, immediate ready
    lat = 1; p_rdat = 8'hEE;
    wr = 4'b0001; addr[0 +: AW] = 8'hA8; wdat[0 +: DW] = 8'h3C; req = 4'b0001;
    @(negedge clk); n = 1;
    chk("wr_pwr", 32'(p_wr), 32'h1);
    chk("wr_wdat", 32'(p_wdat), 32'h3C);
    begin int m; wait_done(40, m); n += m; end
    chk("wr_latency", 32'(n), 32'd2);
    chk("wr_done", 32'(done), 32'h1);
    chk("wr_rdat_kept", 32'(rdat), 32'h5A);
    finish_txn();

    // Round robin from a fresh pointer
    rst = 1; @(negedge clk); rst = 0;
    glog.delete();
    wr = '0; lat = 1;
    for (int k = 0; k < NREQ; k++) addr[k*AW +: AW] = 8'(8'h10 + k);
    req = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      wait_done(40, n);
      if (g == 4) req = 4'b1010;
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);
    chk("rr_count", 32'(glog.size()), 32'd8);
    for (int g = 0; g < 8; g++)
      if (g < glog.size()) chk("rr_order", 32'(glog[g]), 32'(exp_order[g]));

    // Timeout on a read
    lat = 0; wr = '0; addr[2*AW +: AW] = 8'h55; req = 4'b0100;
    wait_done(40, n);
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_sel_len", 32'(sel_len), 32'd15);
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_rdat", 32'(rdat), 32'hFF);
    finish_txn();

    // Next grant clears err
    lat = 1; p_rdat = 8'h11; req = 4'b0010;
    @(negedge clk);
    chk("clr_gnt", 32'(gnt), 32'h2);
    chk("clr_err", 32'(err), 32'h0);
    wait_done(40, n);
    chk("clr_rdat", 32'(rdat), 32'h11);
    finish_txn();

    // Ready on the last allowed cycle wins over timeout
    lat = TMO; p_rdat = 8'hA5; req = 4'b1000;
    wait_done(40, n);
    chk("bnd_err", 32'(err), 32'h0);
    chk("bnd_rdat", 32'(rdat), 32'hA5);
    chk("bnd_sel_len", 32'(sel_len), 32'd15);
    finish_txn();

    // Asynchronous reset in the middle of an access
    lat = 0; req = 4'b0001;
    repeat (4) @(negedge clk);
    chk("mid_psel", 32'(p_sel), 32'h1);
    #1 rst = 1;
    #1;
    chk("arst_psel", 32'(p_sel), 32'h0);
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 0; lat = 1; req = 4'b1001;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    wait_done(40, n);
    finish_txn();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
